// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two-port round-robin arbiter and sequencer in front of the
// combinational half-precision FPU. One operation in flight at a time:
// accept, hold operands on the FPU for FPU_LAT cycles, capture, respond.
module fpu_arbiter #(
  parameter int unsigned FPU_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_vld,
  output logic        o_req0_rdy,
  input  logic        i_req1_vld,
  output logic        o_req1_rdy,
  input  logic [15:0] i_req0_a,
  input  logic [15:0] i_req0_b,
  input  logic [15:0] i_req1_a,
  input  logic [15:0] i_req1_b,
  input  logic [3:0]  i_req0_op,
  input  logic [3:0]  i_req1_op,
  output logic        o_rsp0_vld,
  output logic        o_rsp1_vld,
  input  logic        i_rsp0_rdy,
  input  logic        i_rsp1_rdy,
  output logic [15:0] o_rsp_res,
  output logic        o_rsp_ovf,
  output logic        o_rsp_err,
  output logic        o_fpu_vld,
  output logic [15:0] o_fpu_a,
  output logic [15:0] o_fpu_b,
  output logic [3:0]  o_fpu_op,
  input  logic [15:0] i_fpu_res,
  input  logic        i_fpu_ovf,
  output logic        o_busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0]   OP_ADD      = 4'b1110;
  localparam logic [OP_W-1:0]   OP_MUL      = 4'b1111;
  localparam logic [DATA_W-1:0] RES_ILLEGAL = 16'h7E00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_id_q, gnt_id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic              any_req;
  logic              gnt_port;
  logic              req_open;
  logic [OP_W-1:0]   sel_op;
  logic              rsp_taken;

  // Round-robin grant: a lone requester wins, a tie goes to the port that was not last.
  always_comb begin
    any_req  = i_req0_vld | i_req1_vld;
    gnt_port = 1'b0;
    if (i_req0_vld && i_req1_vld) begin
      gnt_port = ~last_q;
    end else if (i_req1_vld) begin
      gnt_port = 1'b1;
    end
    sel_op    = gnt_port ? i_req1_op : i_req0_op;
    req_open  = (state_q == S_IDLE) && !i_rst;
    rsp_taken = gnt_id_q ? i_rsp1_rdy : i_rsp0_rdy;
  end

  // Request ready is combinational and masked while reset is asserted.
  assign o_req0_rdy = req_open & i_req0_vld & ~gnt_port;
  assign o_req1_rdy = req_open & i_req1_vld &  gnt_port;

  // Outputs decoded straight from registered state.
  assign o_fpu_vld  = (state_q == S_ISSUE);
  assign o_rsp0_vld = (state_q == S_RESP) && !gnt_id_q;
  assign o_rsp1_vld = (state_q == S_RESP) &&  gnt_id_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_fpu_a    = a_q;
  assign o_fpu_b    = b_q;
  assign o_fpu_op   = op_q;
  assign o_rsp_res  = res_q;
  assign o_rsp_ovf  = ovf_q;
  assign o_rsp_err  = err_q;

  // Next-state and datapath load logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_id_d = gnt_id_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        // In IDLE (out of reset) any valid request is a handshake with the winner.
        if (any_req) begin
          gnt_id_d = gnt_port;
          last_d   = gnt_port;
          a_d      = gnt_port ? i_req1_a : i_req0_a;
          b_d      = gnt_port ? i_req1_b : i_req0_b;
          op_d     = sel_op;
          if (sel_op == OP_ADD || sel_op == OP_MUL) begin
            state_d = S_ISSUE;
            cnt_d   = CNT_W'(FPU_LAT - 1);
          end else begin
            // Illegal opcode bypasses the FPU entirely.
            state_d = S_RESP;
            res_d   = RES_ILLEGAL;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          res_d   = i_fpu_res;
          ovf_d   = i_fpu_ovf;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_taken) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      gnt_id_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_id_q <= gnt_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: directed bench with a response scoreboard; a table-driven
// FPU stand-in supplies results only while o_fpu_vld is high.
module tb_fpu_arbiter;

  logic        clk;
  logic        rst;
  logic        v0, v1, r0, r1;
  logic [15:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        rv0, rv1, rr0, rr1;
  logic [15:0] res;
  logic        ovf, err;
  logic        fvld;
  logic [15:0] fa, fb, fres;
  logic [3:0]  fop;
  logic        fovf;
  logic        busy;

  // second instance with FPU_LAT=3
  logic        t_v0, t_r0, t_v1, t_r1, t_rv0, t_rv1, t_rr0, t_rr1;
  logic [15:0] t_a0, t_b0, t_a1, t_b1, t_res, t_fa, t_fb, t_fres;
  logic [3:0]  t_op0, t_op1, t_fop;
  logic        t_ovf, t_err, t_fvld, t_fovf, t_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [18:0] sb[$];

  fpu_arbiter #(.FPU_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_vld(v0), .o_req0_rdy(r0), .i_req1_vld(v1), .o_req1_rdy(r1),
    .i_req0_a(a0), .i_req0_b(b0), .i_req1_a(a1), .i_req1_b(b1),
    .i_req0_op(op0), .i_req1_op(op1),
    .o_rsp0_vld(rv0), .o_rsp1_vld(rv1), .i_rsp0_rdy(rr0), .i_rsp1_rdy(rr1),
    .o_rsp_res(res), .o_rsp_ovf(ovf), .o_rsp_err(err),
    .o_fpu_vld(fvld), .o_fpu_a(fa), .o_fpu_b(fb), .o_fpu_op(fop),
    .i_fpu_res(fres), .i_fpu_ovf(fovf), .o_busy(busy)
  );

  fpu_arbiter #(.FPU_LAT(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_req0_vld(t_v0), .o_req0_rdy(t_r0), .i_req1_vld(t_v1), .o_req1_rdy(t_r1),
    .i_req0_a(t_a0), .i_req0_b(t_b0), .i_req1_a(t_a1), .i_req1_b(t_b1),
    .i_req0_op(t_op0), .i_req1_op(t_op1),
    .o_rsp0_vld(t_rv0), .o_rsp1_vld(t_rv1), .i_rsp0_rdy(t_rr0), .i_rsp1_rdy(t_rr1),
    .o_rsp_res(t_res), .o_rsp_ovf(t_ovf), .o_rsp_err(t_err),
    .o_fpu_vld(t_fvld), .o_fpu_a(t_fa), .o_fpu_b(t_fb), .o_fpu_op(t_fop),
    .i_fpu_res(t_fres), .i_fpu_ovf(t_fovf), .o_busy(t_busy)
  );

  // Known fp16 results for the operand pairs used here; garbage when not driven.
  function automatic logic [16:0] fpu_model(input logic vld, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] op);
    if (!vld) return {1'b0, 16'hBAD0};
    case ({op, a, b})
      {4'hE, 16'h3C00, 16'h4000}: return {1'b0, 16'h4200};
      {4'hF, 16'hC000, 16'h4200}: return {1'b0, 16'hC600};
      {4'hE, 16'h4500, 16'h4200}: return {1'b0, 16'h4800};
      {4'hF, 16'h3E00, 16'h4400}: return {1'b0, 16'h4600};
      {4'hF, 16'h7BFF, 16'h4000}: return {1'b1, 16'h7C00};
      default:                    return {1'b0, 16'hDEAD};
    endcase
  endfunction

  always_comb {fovf, fres}     = fpu_model(fvld, fa, fb, fop);
  always_comb {t_fovf, t_fres} = fpu_model(t_fvld, t_fa, t_fb, t_fop);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic port, input logic [15:0] r, input logic o, input logic e);
    sb.push_back({port, o, e, r});
  endtask

  // Compare the current response against the oldest expected entry.
  task automatic pop_cmp();
    logic [18:0] e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_vld_win", 32'(e[18] ? rv1 : rv0), 32'd1);
      chk("rsp_vld_other", 32'(e[18] ? rv0 : rv1), 32'd0);
      chk("rsp_res", 32'(res), 32'(e[15:0]));
      chk("rsp_ovf", 32'(ovf), 32'(e[17]));
      chk("rsp_err", 32'(err), 32'(e[16]));
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!(rv0 || rv1) && n < 30) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 32'(rv0 | rv1), 32'd1);
    pop_cmp();
    tick();
  endtask

  task automatic accept(input logic port, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op);
    int n = 0;
    if (port) begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    else      begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    #1;
    while (!(port ? r1 : r0) && n < 30) begin
      tick();
      #1;
      n++;
    end
    chk("req_rdy", 32'(port ? r1 : r0), 32'd1);
    tick();
    if (port) v1 = 1'b0;
    else      v0 = 1'b0;
  endtask

  initial begin
    int g;
    int r;
    int gp[4];
    int gc[4];
    bit drop;

    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = 4'hE; op1 = 4'hE;
    rr0 = 1'b1; rr1 = 1'b1;
    t_v0 = 1'b0; t_v1 = 1'b0; t_a0 = '0; t_b0 = '0; t_a1 = '0; t_b1 = '0;
    t_op0 = 4'hE; t_op1 = 4'hE; t_rr0 = 1'b1; t_rr1 = 1'b1;

    // reset values, request ready masked during reset
    #2;
    chk("rst_rdy0", 32'(r0), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({rv0, rv1, fvld, ovf, err}), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_fa", 32'(fa), 32'd0);
    chk("rst_fop", 32'(fop), 32'hE);
    v0 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // port 0 add with exact cycle timing
    v0 = 1'b1; a0 = 16'h3C00; b0 = 16'h4000; op0 = 4'hE;
    #1;
    chk("t1_rdy0", 32'(r0), 32'd1);
    chk("t1_rdy1", 32'(r1), 32'd0);
    sb_push(1'b0, 16'h4200, 1'b0, 1'b0);
    tick();
    v0 = 1'b0;
    chk("t1_fvld_k1", 32'(fvld), 32'd1);
    chk("t1_fa", 32'(fa), 32'h3C00);
    chk("t1_fb", 32'(fb), 32'h4000);
    chk("t1_fop", 32'(fop), 32'hE);
    chk("t1_rsp_k1", 32'(rv0), 32'd0);
    tick();
    chk("t1_fvld_k2", 32'(fvld), 32'd0);
    chk("t1_fa_hold", 32'(fa), 32'h3C00);
    pop_cmp();
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // port 1 multiply alone
    sb_push(1'b1, 16'hC600, 1'b0, 1'b0);
    accept(1'b1, 16'hC000, 16'h4200, 4'hF);
    wait_rsp();

    // both ports valid continuously: alternation and spacing
    v0 = 1'b1; a0 = 16'h4500; b0 = 16'h4200; op0 = 4'hE;
    v1 = 1'b1; a1 = 16'h3E00; b1 = 16'h4400; op1 = 4'hF;
    g = 0; r = 0; drop = 1'b0;
    for (int it = 0; it < 60 && r < 4; it++) begin
      #1;
      if (rv0 || rv1) begin
        pop_cmp();
        r++;
      end
      if ((r0 || r1) && g < 4) begin
        gp[g] = r1 ? 1 : 0;
        gc[g] = cyc;
        if (r1) sb_push(1'b1, 16'h4600, 1'b0, 1'b0);
        else    sb_push(1'b0, 16'h4800, 1'b0, 1'b0);
        g++;
        if (g == 4) drop = 1'b1;
      end
      tick();
      if (drop) begin v0 = 1'b0; v1 = 1'b0; end
    end
    chk("t3_rsp_count", 32'(r), 32'd4);
    for (int i = 0; i < g; i++) begin
      chk("t3_grant", 32'(gp[i]), 32'(i % 2));
      if (i > 0) chk("t3_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
    end

    // illegal opcode, response backpressure, pending port 1 request
    rr0 = 1'b0;
    v0 = 1'b1; a0 = 16'h1234; b0 = 16'h5678; op0 = 4'b0011;
    #1;
    chk("t4_rdy0", 32'(r0), 32'd1);
    sb_push(1'b0, 16'h7E00, 1'b0, 1'b1);
    tick();
    v0 = 1'b0;
    v1 = 1'b1; a1 = 16'hC000; b1 = 16'h4200; op1 = 4'hF;
    #1;
    chk("t4_fvld", 32'(fvld), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_rdy1_blocked", 32'(r1), 32'd0);
    pop_cmp();
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("t4_hold_vld", 32'({rv0, rv1}), 32'b10);
      chk("t4_hold_res", 32'({err, ovf, res}), 32'({1'b1, 1'b0, 16'h7E00}));
      chk("t4_hold_busy", 32'(busy), 32'd1);
      chk("t4_hold_rdy1", 32'(r1), 32'd0);
      chk("t4_hold_fvld", 32'(fvld), 32'd0);
    end
    rr0 = 1'b1;
    #1;
    chk("t4_rdy1_hs_cycle", 32'(r1), 32'd0);
    sb_push(1'b1, 16'hC600, 1'b0, 1'b0);
    tick();
    #1;
    chk("t4_rdy1_after", 32'(r1), 32'd1);
    chk("t4_rsp0_done", 32'(rv0), 32'd0);
    tick();
    v1 = 1'b0;
    wait_rsp();

    // FPU_LAT=3 instance, overflow pass-through
    t_v0 = 1'b1; t_a0 = 16'h7BFF; t_b0 = 16'h4000; t_op0 = 4'hF;
    #1;
    chk("t5_rdy0", 32'(t_r0), 32'd1);
    tick();
    t_v0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_fvld", 32'(t_fvld), 32'd1);
      chk("t5_no_rsp", 32'(t_rv0), 32'd0);
      tick();
    end
    chk("t5_fvld_end", 32'(t_fvld), 32'd0);
    chk("t5_rsp_vld", 32'({t_rv0, t_rv1}), 32'b10);
    chk("t5_res", 32'(t_res), 32'h7C00);
    chk("t5_ovf", 32'(t_ovf), 32'd1);
    chk("t5_err", 32'(t_err), 32'd0);
    tick();
    chk("t5_idle", 32'({t_busy, t_r1}), 32'd0);

    // reset pulsed during ISSUE drops the operation
    v0 = 1'b1; a0 = 16'h3C00; b0 = 16'h4000; op0 = 4'hE;
    #1;
    chk("t6_rdy0", 32'(r0), 32'd1);
    tick();
    v0 = 1'b0;
    chk("t6_in_issue", 32'(fvld), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({fvld, busy, rv0, rv1, ovf, err}), 32'd0);
    chk("t6_rst_res", 32'(res), 32'd0);
    chk("t6_rst_fa", 32'(fa), 32'd0);
    chk("t6_rst_fop", 32'(fop), 32'hE);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_rsp", 32'({rv0, rv1, busy}), 32'd0);
    end
    sb_push(1'b1, 16'hC600, 1'b0, 1'b0);
    accept(1'b1, 16'hC000, 16'h4200, 4'hF);
    wait_rsp();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Two-port round-robin arbiter and sequencer for the half-precision FPU. The CPU core (port 0) and the crypto core (port 1) share the FPU through it. For each operation it accepts one request, latches the operands, drives the FPU for a fixed number of cycles, captures the result and overflow flag, and returns them to the winning requester over a valid/ready handshake. It sits between the requesters and the combinational `fpu` instance.

## Interface
- `FPU_LAT`, default 1: cycles the operands are held on the FPU before capture (range 1–15).
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous reset, active-high.
- `i_req0_vld` / `i_req1_vld` in 1: request valid, per port.
- `o_req0_rdy` / `o_req1_rdy` out 1: request accepted this cycle, per port.
- `i_req0_a`, `i_req0_b`, `i_req1_a`, `i_req1_b` in 16: fp16 operands.
- `i_req0_op` / `i_req1_op` in 4: opcode. 4'b1110 is add, 4'b1111 is multiply; all others are illegal.
- `o_rsp0_vld` / `o_rsp1_vld` out 1: response valid, per port.
- `i_rsp0_rdy` / `i_rsp1_rdy` in 1: response taken, per port.
- `o_rsp_res` out 16: result (shared by both ports).
- `o_rsp_ovf` out 1: FPU overflow flag (shared).
- `o_rsp_err` out 1: illegal-opcode flag (shared).
- `o_fpu_vld` out 1: drives the FPU `i_vld`.
- `o_fpu_a`, `o_fpu_b` out 16: drive the FPU `i_a` / `i_b`.
- `o_fpu_op` out 4: drives the FPU `opcode`.
- `i_fpu_res` in 16: from FPU `o_res`.
- `i_fpu_ovf` in 1: from FPU `overflow`.
- `o_busy` out 1: high whenever state is not IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE:**
  - The grant is combinational from the two `i_reqN_vld` inputs and the `last` pointer.
  - With a single valid request, that port wins.
  - With both valid, the port that is not `last` wins.
  - `o_reqN_rdy = (state==IDLE) && grant==N`.
  - On a handshake (vld && rdy): latch a, b, op and the port id into `gnt_id`, and set `last = gnt_id`.
  - A legal opcode goes to ISSUE with the counter loaded to `FPU_LAT-1`.
  - An illegal opcode goes straight to RESP with result 16'h7E00, ovf 0, err 1. The FPU is never driven in this case.
- **ISSUE:**
  - `o_fpu_vld=1`, and `o_fpu_a/b/op` carry the latched values.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: capture `i_fpu_res` and `i_fpu_ovf` into the response registers with err 0, then go to RESP.
- **RESP:**
  - `o_rspN_vld=1` for N == `gnt_id` only; res/ovf/err are held stable.
  - On `i_rspN_rdy` (same N), go to IDLE.
  - The `i_rsp` ready of the non-granted port is ignored.
- **Request-side rules:**
  - Requests arriving in ISSUE or RESP are not accepted; rdy stays 0.
  - Requesters must hold vld and operands stable until rdy.
  - A requester dropping vld before acceptance is legal; no operation occurs.
- **Outside ISSUE:** `o_fpu_vld=0` and `o_fpu_a/b/op` hold their last latched values.
- **Pass-through only:** the block does no arithmetic. Special values (Inf, NaN, zero) and the overflow flag come solely from the FPU.

## Timing
- **Reset (asynchronous):**
  - State goes to IDLE and `last` goes to 1, so port 0 wins the first tie.
  - Latched a/b/res go to 16'h0000, op goes to 4'b1110, `gnt_id` goes to 0.
  - All `o_*_vld`, `o_*_rdy`, `o_rsp_ovf`, `o_rsp_err` and `o_busy` go to 0; `o_rsp_res` goes to 0.
- **Reset mid-operation:** the in-flight operation is dropped and no response is ever issued for it. After reset deasserts, the first rising edge is evaluated from IDLE.
- **Latency, legal op, acceptance in cycle k:**
  - ISSUE in cycles k+1 .. k+FPU_LAT.
  - `o_rspN_vld` is high from cycle k+FPU_LAT+1.
  - With ready held high: IDLE in cycle k+FPU_LAT+2, and the next acceptance can happen that same cycle.
  - Minimum spacing is FPU_LAT+2 cycles, i.e. 3 cycles with the default.
- **Latency, illegal op:** response is valid in cycle k+1.
- **Response backpressure:** the response is held indefinitely and `o_busy` stays 1.
- **Simultaneous events:**
  - A new request asserted in the same cycle the response handshakes is not accepted until the following (IDLE) cycle.
  - Both ports valid continuously gives strict alternation 0,1,0,1.

## Test plan
- Port 0 sends add, a=16'h3C00, b=16'h4000 -> `o_fpu_vld` is high exactly 1 cycle; `o_rsp0_vld` in cycle k+2 with res 16'h4200, ovf 0, err 0; `o_rsp1_vld` stays 0.
- Port 1 sends mul, 16'hC000 × 16'h4200 -> `o_rsp1_vld` with res 16'hC600; the next idle tie is won by port 0.
- Both ports valid from reset for 4 ops (port 0 adds 16'h4500+16'h4200, port 1 multiplies 16'h3E00×16'h4400) -> grants alternate 0,1,0,1; results are 16'h4800 and 16'h4600; accept spacing is exactly 3 cycles.
- Port 0 op=4'b0011 -> `o_fpu_vld` never asserts; response next cycle with res 16'h7E00, err 1. Then `i_rsp0_rdy` is held low 5 cycles -> response held stable, `o_busy`=1, port 1's pending request is not accepted until after the handshake.
- Mul 16'h7BFF × 16'h4000 with `FPU_LAT`=3 -> `o_fpu_vld` is high 3 cycles; response carries the FPU result 16'h7C00 with ovf 1.
- `i_rst` pulsed during ISSUE -> all outputs 0 immediately; no response is issued; a new port 1 request after reset completes normally.
